muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_sequencer.sv | 151 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared datapath definitions for the multiply/divide unit: operation
// encodings, sequencer state encodings and small op-decode helpers.
package muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic op_is_div(op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath on the 2*WIDTH accumulator.
// Multiply: acc = {partial product, multiplier}, add-then-shift-right.
// Divide:   acc = {remainder, dividend/quotient}, restoring shift-subtract.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  // Single combinational step; diff[WIDTH] set means the trial subtract borrowed.
  always_comb begin
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    diff      = rem_shift - {1'b0, opnd};
    acc_next  = '0;
    if (is_div) begin
      if (!diff[WIDTH]) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and pipeline stall.
//
// state  | meaning
// IDLE   | waiting for Start; Hi/Lo writable
// RUN    | WIDTH iterations of the shift-add / shift-subtract step
// FIX    | sign correction of the result, Hi/Lo loaded on exit
// DONE   | one cycle, result valid in Hi/Lo; Start here chains a new op
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiLoRead,
  input  logic [1:0]       HiLoWrite,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               state, state_nxt;
  logic                 accept;
  logic [CW-1:0]        count;
  op_e                  op_in, op_q;
  logic                 is_div_q;
  logic [2*WIDTH-1:0]   acc_q, acc_step, prod;
  logic [WIDTH-1:0]     opnd_q, a_raw_q;
  logic                 neg_res_q, neg_rem_q, div_zero_q;
  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     res_hi, res_lo, hi_q, lo_q;

  assign op_in    = op_e'(Op);
  assign is_div_q = op_is_div(op_q);

  // Operand magnitudes for the unsigned core; signs are restored in FIX.
  always_comb begin
    sign_a = op_is_signed(op_in) & A[WIDTH-1];
    sign_b = op_is_signed(op_in) & B[WIDTH-1];
    mag_a  = sign_a ? -A : A;
    mag_b  = sign_b ? -B : B;
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs; Start while busy is dropped but stalls.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: if (Start) begin
        state_nxt = S_RUN;
        accept    = 1'b1;
      end
      S_RUN:  if (count == LAST) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: begin
        state_nxt = Start ? S_RUN : S_IDLE;
        accept    = Start;
      end
      default: state_nxt = S_IDLE;
    endcase
    Busy      = (state == S_RUN) || (state == S_FIX);
    Stall     = Busy & (HiLoRead | (|HiLoWrite) | Start);
    Done      = (state == S_DONE);
    DivByZero = (state == S_DONE) & div_zero_q;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .opnd     (opnd_q),
    .is_div   (is_div_q),
    .acc_next (acc_step)
  );

  // Operand latch on accept, then one datapath step per RUN cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count      <= '0;
      op_q       <= OP_MULT;
      acc_q      <= '0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (accept) begin
      count      <= '0;
      op_q       <= op_in;
      acc_q      <= op_is_div(op_in) ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
      opnd_q     <= op_is_div(op_in) ? mag_b : mag_a;
      a_raw_q    <= A;
      neg_res_q  <= sign_a ^ sign_b;
      neg_rem_q  <= sign_a & op_is_div(op_in);
      div_zero_q <= op_is_div(op_in) & (B == '0);
    end else if (state == S_RUN) begin
      acc_q <= acc_step;
      count <= count + 1'b1;
    end
  end

  // Sign fix-up; divide-by-zero returns the dividend untouched and all-ones.
  always_comb begin
    prod   = neg_res_q ? -acc_q : acc_q;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        res_hi = a_raw_q;
        res_lo = '1;
      end else begin
        res_hi = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        res_lo = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end
    end
  end

  // HI/LO: result load from FIX wins; MTHI/MTLO only when the unit is idle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == S_FIX) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (!Busy) begin
      if (HiLoWrite[1]) hi_q <= WrData;
      if (HiLoWrite[0]) lo_q <= WrData;
    end
  end

  assign Hi = hi_q;
  assign Lo = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus corner sequences.
module tb_muldiv_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        HiLoRead = 1'b0;
  logic [1:0]  HiLoWrite = 2'd0;
  logic [31:0] WrData = '0;
  logic        Busy, Stall, Done, DivByZero;
  logic [31:0] Hi, Lo;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[14];

  muldiv_sequencer #(.WIDTH(32)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .HiLoRead  (HiLoRead),
    .HiLoWrite (HiLoWrite),
    .WrData    (WrData),
    .Busy      (Busy),
    .Stall     (Stall),
    .Done      (Done),
    .DivByZero (DivByZero),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Issues an op in the current cycle and follows it to its Done cycle (34).
  // Returns at the sample point of cycle 34 with Start low.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic edz);
    Start = 1'b1; Op = op; A = a; B = b;
    cyc();
    Start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      #1;
      chk($sformatf("%s busy c%0d", tag, c), {63'd0, Busy}, {63'd0, c <= 33});
      chk($sformatf("%s done c%0d", tag, c), {63'd0, Done}, {63'd0, c == 34});
      if (c == 34) begin
        chk($sformatf("%s hi", tag), {32'd0, Hi}, {32'd0, ehi});
        chk($sformatf("%s lo", tag), {32'd0, Lo}, {32'd0, elo});
        chk($sformatf("%s dz", tag), {63'd0, DivByZero}, {63'd0, edz});
      end else begin
        cyc();
      end
    end
  endtask

  initial begin
    int done_cnt;

    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[6]  = '{MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'd0,        32'd15,       1'b0};
    vecs[7]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[10] = '{MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0};
    vecs[11] = '{DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
    vecs[12] = '{MULT,  32'd7,        32'd0,        32'd0,        32'd0,        1'b0};
    vecs[13] = '{DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 1'b0};

    // Reset state
    Reset = 1'b1;
    cyc(); cyc();
    Reset = 1'b0;
    #1;
    chk("rst busy", {63'd0, Busy}, 64'd0);
    chk("rst stall", {63'd0, Stall}, 64'd0);
    chk("rst done", {63'd0, Done}, 64'd0);
    chk("rst dz", {63'd0, DivByZero}, 64'd0);
    chk("rst hi", {32'd0, Hi}, 64'd0);
    chk("rst lo", {32'd0, Lo}, 64'd0);

    // Idle MTHI / MTLO
    cyc();
    HiLoWrite = 2'b10; WrData = 32'h0000AAAA;
    cyc();
    HiLoWrite = 2'b01; WrData = 32'h00005555;
    cyc();
    HiLoWrite = 2'b00;
    #1;
    chk("mthi", {32'd0, Hi}, 64'h0000AAAA);
    chk("mtlo", {32'd0, Lo}, 64'h00005555);

    // HiLoRead stall window, ignored Start, ignored busy write
    cyc();
    Start = 1'b1; Op = MULTU; A = 32'd3; B = 32'd4;
    cyc();
    Start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 45; c++) begin
      HiLoRead  = (c >= 5 && c <= 40);
      Start     = (c == 10);
      if (c == 10) begin Op = DIVU; A = 32'd1; B = 32'd0; end
      HiLoWrite = (c == 20) ? 2'b11 : 2'b00;
      WrData    = 32'hDEADBEEF;
      #1;
      chk($sformatf("rd stall c%0d", c), {63'd0, Stall}, {63'd0, (c >= 5 && c <= 33)});
      if (Done) done_cnt++;
      if (c == 21) begin
        chk("busy write hi", {32'd0, Hi}, 64'h0000AAAA);
        chk("busy write lo", {32'd0, Lo}, 64'h00005555);
      end
      if (c == 34) begin
        chk("rd done", {63'd0, Done}, 64'd1);
        chk("rd hi", {32'd0, Hi}, 64'd0);
        chk("rd lo", {32'd0, Lo}, 64'd12);
        chk("rd dz", {63'd0, DivByZero}, 64'd0);
      end
      cyc();
    end
    HiLoRead = 1'b0; Start = 1'b0; HiLoWrite = 2'b00;
    chk("rd done count", 64'(done_cnt), 64'd1);

    // Start and MTLO in the same idle cycle
    Start = 1'b1; Op = MULTU; A = 32'd2; B = 32'd3;
    HiLoWrite = 2'b01; WrData = 32'h00001234;
    cyc();
    Start = 1'b0; HiLoWrite = 2'b00;
    #1;
    chk("sw lo early", {32'd0, Lo}, 64'h1234);
    chk("sw busy", {63'd0, Busy}, 64'd1);
    for (int c = 2; c <= 34; c++) cyc();
    #1;
    chk("sw done", {63'd0, Done}, 64'd1);
    chk("sw lo", {32'd0, Lo}, 64'd6);
    chk("sw hi", {32'd0, Hi}, 64'd0);
    cyc();

    // Vector table
    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dz);
      cyc();
    end

    // Back-to-back: second Start issued in the DONE cycle of the first
    run_op("b2b first", MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    run_op("b2b second", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    cyc();

    // Reset in cycle 10 of a MULTU
    Start = 1'b1; Op = MULTU; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    cyc();
    Start = 1'b0;
    for (int c = 2; c <= 10; c++) cyc();
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    #1;
    chk("abort busy", {63'd0, Busy}, 64'd0);
    chk("abort hi", {32'd0, Hi}, 64'd0);
    chk("abort lo", {32'd0, Lo}, 64'd0);
    done_cnt = 0;
    for (int c = 11; c <= 40; c++) begin
      if (Done) done_cnt++;
      cyc();
      #1;
    end
    chk("abort no done", 64'(done_cnt), 64'd0);
    run_op("post abort", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    cyc();

    // Reset beats Start and HiLoWrite in the same idle cycle
    Reset = 1'b1; Start = 1'b1; Op = MULTU; A = 32'd5; B = 32'd5;
    HiLoWrite = 2'b11; WrData = 32'h0000FFFF;
    cyc();
    Reset = 1'b0; Start = 1'b0; HiLoWrite = 2'b00;
    #1;
    chk("rprio busy", {63'd0, Busy}, 64'd0);
    chk("rprio hi", {32'd0, Hi}, 64'd0);
    chk("rprio lo", {32'd0, Lo}, 64'd0);
    cyc();
    #1;
    chk("rprio busy2", {63'd0, Busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
